// File: rtl/fc_inbuf_pkg.sv
// Shared types and sizing helpers for the layer input buffer and the func unit that feeds it.
package fc_inbuf_pkg;

    typedef enum logic [1:0] {
        s_ib_fill,
        s_ib_req_wait,
        s_ib_req,
        s_ib_compute
    } t_inbuf_state;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Counter width that stays legal for a range of one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_inbuf_addr_gen.sv
// Row/tile/element write pointer: advances one slot per accepted element, all fields wrap to 0 after the last one.
// Single-cycle update on adv_i; no flow control of its own.
module fc_inbuf_addr_gen
    import fc_inbuf_pkg::*;
#(
    parameter int input_size  = 512,
    parameter int xbar_size   = 256,
    parameter int v_cim_tiles = ceil_div(input_size, xbar_size)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            adv_i,
    output logic [cnt_w(xbar_size)-1:0]     row_o,
    output logic [cnt_w(v_cim_tiles)-1:0]   tile_o,
    output logic                            last_o
);

    localparam int row_w  = cnt_w(xbar_size);
    localparam int tile_w = cnt_w(v_cim_tiles);
    localparam int elem_w = cnt_w(input_size);

    logic [row_w-1:0]  row_q,  row_d;
    logic [tile_w-1:0] tile_q, tile_d;
    logic [elem_w-1:0] elem_q, elem_d;

    assign last_o = (elem_q == elem_w'(input_size - 1));
    assign row_o  = row_q;
    assign tile_o = tile_q;

    always_comb begin
        row_d  = row_q;
        tile_d = tile_q;
        elem_d = elem_q;
        if (adv_i) begin
            if (last_o) begin
                row_d  = '0;
                tile_d = '0;
                elem_d = '0;
            end else begin
                elem_d = elem_q + 1'b1;
                if (row_q == row_w'(xbar_size - 1)) begin
                    row_d  = '0;
                    tile_d = tile_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            tile_q <= '0;
            elem_q <= '0;
        end else begin
            row_q  <= row_d;
            tile_q <= tile_d;
            elem_q <= elem_d;
        end
    end

endmodule

// File: rtl/fc_inbuf.sv
// Packs streamed elements into tile-major crossbar input registers, then requests and holds a CIM operation.
// Element write takes effect on the accepting edge; o_busy stalls upstream from the first element until CIM finishes.
module fc_inbuf
    import fc_inbuf_pkg::*;
#(
    parameter int input_size    = 512,
    parameter int xbar_size     = 256,
    parameter int v_cim_tiles   = ceil_div(input_size, xbar_size),
    parameter int datatype_size = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    i_valid,
    input  logic [datatype_size-1:0]                                i_data,
    output logic                                                    o_busy,
    output logic                                                    o_cim_start,
    input  logic                                                    i_cim_busy,
    output logic [v_cim_tiles-1:0][xbar_size-1:0][datatype_size-1:0] o_data,
    output logic                                                    o_overflow
);

    t_inbuf_state state_q;
    logic         busy_q;
    logic         start_q;
    logic         overflow_q;
    logic [v_cim_tiles-1:0][xbar_size-1:0][datatype_size-1:0] data_q;

    logic [cnt_w(xbar_size)-1:0]   row;
    logic [cnt_w(v_cim_tiles)-1:0] tile;
    logic                          last;
    logic                          accept;

    assign accept = (state_q == s_ib_fill) && i_valid;

    fc_inbuf_addr_gen #(
        .input_size  (input_size),
        .xbar_size   (xbar_size),
        .v_cim_tiles (v_cim_tiles)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (accept),
        .row_o  (row),
        .tile_o (tile),
        .last_o (last)
    );

    // Outputs are registered alongside the state so they switch on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= s_ib_fill;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= '0;
        end else begin
            if (i_valid && (state_q != s_ib_fill)) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                s_ib_fill: begin
                    if (i_valid) begin
                        data_q[tile][row] <= i_data;
                        busy_q            <= 1'b1;
                        if (last) begin
                            if (!i_cim_busy) begin
                                state_q <= s_ib_req;
                                start_q <= 1'b1;
                            end else begin
                                state_q <= s_ib_req_wait;
                            end
                        end
                    end
                end
                s_ib_req_wait: begin
                    if (!i_cim_busy) begin
                        state_q <= s_ib_req;
                        start_q <= 1'b1;
                    end
                end
                s_ib_req: begin
                    if (i_cim_busy) begin
                        state_q <= s_ib_compute;
                        start_q <= 1'b0;
                    end
                end
                s_ib_compute: begin
                    if (!i_cim_busy) begin
                        state_q <= s_ib_fill;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= s_ib_fill;
                    busy_q  <= 1'b0;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_cim_start = start_q;
    assign o_overflow  = overflow_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_fc_inbuf.sv
// Directed vector bench for fc_inbuf with a 5-element vector over two 4-row tiles.
module tb_fc_inbuf;

    logic                      clk;
    logic                      rst;
    logic                      i_valid;
    logic [7:0]                i_data;
    logic                      o_busy;
    logic                      o_cim_start;
    logic                      i_cim_busy;
    logic [1:0][3:0][7:0]      o_data;
    logic                      o_overflow;

    int n_cmp = 0;
    int n_err = 0;

    fc_inbuf #(
        .input_size    (5),
        .xbar_size     (4),
        .v_cim_tiles   (2),
        .datatype_size (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_busy      (o_busy),
        .o_cim_start (o_cim_start),
        .i_cim_busy  (i_cim_busy),
        .o_data      (o_data),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        cb;
        logic        eb;
        logic        es;
        logic        eo;
        logic        cd;
        logic [63:0] ed;
    } vec_t;

    vec_t vec [21];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step(input logic v, input logic [7:0] d, input logic cb);
        i_valid    = v;
        i_data     = d;
        i_cim_busy = cb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string nm, input int idx, input logic eb, input logic es, input logic eo);
        chk({nm, "_busy"}, idx, 64'(o_busy), 64'(eb));
        chk({nm, "_start"}, idx, 64'(o_cim_start), 64'(es));
        chk({nm, "_ovf"}, idx, 64'(o_overflow), 64'(eo));
    endtask

    localparam logic [63:0] D1 = 64'h00000005_04030201;
    localparam logic [63:0] D3 = 64'h00000045_44434241;

    initial begin
        //            v  d      cb  eb  es  eo  cd  ed
        vec[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1};
        vec[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0201};
        vec[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vec[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vec[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, D1};
        vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, D1};
        vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, D1};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, D1};
        vec[8]  = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D1};
        vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D1};
        vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D1};
        vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, D1};
        vec[12] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000005_04030241};
        vec[13] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        vec[14] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        vec[15] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        vec[16] = '{1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D3};
        vec[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D3};
        vec[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, D3};
        vec[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, D3};
        vec[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, D3};

        rst        = 1'b1;
        i_valid    = 1'b0;
        i_data     = 8'h00;
        i_cim_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_ctl("reset", 0, 1'b0, 1'b0, 1'b0);
        chk("reset_data", 0, o_data, 64'h0);
        rst = 1'b0;

        // Nominal fill, CIM handshake, overflow in compute, CIM busy at completion.
        for (int i = 0; i < 21; i++) begin
            step(vec[i].v, vec[i].d, vec[i].cb);
            chk_ctl("tbl", i, vec[i].eb, vec[i].es, vec[i].eo);
            if (vec[i].cd) chk("tbl_data", i, o_data, vec[i].ed);
        end

        // Gapped stream, then a second back-to-back vector overwriting it.
        step(1'b1, 8'h09, 1'b0); chk("gap_busy", 0, 64'(o_busy), 64'h1);
        step(1'b0, 8'h00, 1'b0); chk("gap_busy", 1, 64'(o_busy), 64'h1);
        step(1'b1, 8'h0a, 1'b0);
        step(1'b1, 8'h0b, 1'b0);
        step(1'b0, 8'h00, 1'b0); chk("gap_start", 0, 64'(o_cim_start), 64'h0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h0c, 1'b0); chk("gap_start", 1, 64'(o_cim_start), 64'h0);
        step(1'b1, 8'h0d, 1'b0); chk("gap_start", 2, 64'(o_cim_start), 64'h1);
        chk("gap_data", 0, o_data, 64'h0000000d_0c0b0a09);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0); chk("gap_busy", 2, 64'(o_busy), 64'h0);
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h14 + k), 1'b0);
        chk("vec2_start", 0, 64'(o_cim_start), 64'h1);
        chk("vec2_data", 0, o_data, 64'h00000018_17161514);
        chk("vec2_ovf", 0, 64'(o_overflow), 64'h1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0); chk("vec2_busy", 0, 64'(o_busy), 64'h0);

        // Reset in the middle of a partial fill.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("mid_data", 0, o_data, 64'h00000018_17333231);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk_ctl("midrst", 0, 1'b0, 1'b0, 1'b0);
        chk("midrst_data", 0, o_data, 64'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h51 + k), 1'b0);
        chk("fresh_start", 0, 64'(o_cim_start), 64'h0);
        step(1'b1, 8'h55, 1'b0);
        chk_ctl("fresh", 0, 1'b1, 1'b1, 1'b0);
        chk("fresh_data", 0, o_data, 64'h00000055_54535251);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
